dmem_unit: RTL

Data-memory stage that sits directly downstream of the pipelined RV32I core's MEM-stage outputs (address, store data, read/write strobes).
- Performs byte/halfword/word stores with lane masking.
- Returns load data extended to 32 bits, combinationally within the same MEM cycle, so the core's MEM/WB register captures it.
- Tracks misaligned accesses with a sticky error record.
- Keeps load/store access counters.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dm_lane_fmt.sv | 61 ++++++
 rtl/dmem_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory stage.
// Holds the access size/sign codes carried on dm_type and the
// memory-mapped register map used when DM_MMIO_EN is defined.
package dmem_pkg;

    // Access size / sign codes on dm_type. Codes 3'b101..3'b111 are undefined
    // and are treated as a no-op by the memory stage.
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    // Memory-mapped register window: addr[31:16] selects it, addr[15:0] the register.
    localparam logic [15:0] MMIO_BASE_HI       = 16'hFFFF;
    localparam logic [15:0] MMIO_CYCLE_OFS     = 16'h0000;
    localparam logic [15:0] MMIO_LOAD_CNT_OFS  = 16'h0004;
    localparam logic [15:0] MMIO_STORE_CNT_OFS = 16'h0008;
    localparam logic [15:0] MMIO_GPIO_OFS      = 16'h000C;

endpackage

// File: rtl/dm_lane_fmt.sv
// dm_lane_fmt: combinational byte-lane steering for the data-memory stage.
// Store side: byte enables and store data replicated into the addressed lanes.
// Load side: extraction of the addressed byte/half and sign/zero extension.
// Also reports whether dm_type is a defined code and whether the access is
// naturally aligned for its size.
module dm_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_dm_type,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_aligned,
    output logic        o_valid
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    assign w_byte = i_rword[8*i_addr_lo +: 8];

    // Decode size/sign code into lane enables, store data and extended load data.
    always_comb begin
        // NOTE: every output is given a default first so no path through the case infers a latch.
        o_be      = 4'b0000;
        o_wdata   = 32'h0;
        o_rdata   = 32'h0;
        o_aligned = 1'b0;
        o_valid   = 1'b1;
        case (i_dm_type)
            DM_WORD: begin
                o_aligned = (i_addr_lo == 2'b00);
                o_be      = 4'b1111;
                o_wdata   = i_wdata;
                o_rdata   = i_rword;
            end
            DM_HALF, DM_HALF_U: begin
                o_aligned = ~i_addr_lo[0];
                o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata   = {2{i_wdata[15:0]}};
                o_rdata   = (i_dm_type == DM_HALF) ? {{16{w_half[15]}}, w_half}
                                                   : {16'h0, w_half};
            end
            DM_BYTE, DM_BYTE_U: begin
                o_aligned = 1'b1;
                o_be      = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_wdata[7:0]}};
                o_rdata   = (i_dm_type == DM_BYTE) ? {{24{w_byte[7]}}, w_byte}
                                                   : {24'h0, w_byte};
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: data-memory stage behind the RV32I MEM stage.
// Byte/half/word stores with lane masking, asynchronous extended loads,
// sticky misalignment record and load/store access counters.
// Optional feature macro: DM_MMIO_EN -- when defined, addr[31:16]==16'hFFFF
// decodes to a cycle counter, the two access counters and a GPIO output
// register instead of RAM. When undefined those addresses alias into RAM and
// gpio_out is tied to zero.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_type,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        err_sticky,
    output logic [31:0] err_addr,
    input  logic        err_clr,
    output logic [31:0] gpio_out
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic [31:0]      r_load_cnt;
    logic [31:0]      r_store_cnt;
    logic             r_err_sticky;
    logic [31:0]      r_err_addr;

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rword;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_al;
    logic [31:0]      w_rdata_ext;
    logic             w_aligned;
    logic             w_valid;
    logic             w_is_mmio;
    logic             w_access;
    logic             w_misalign;
    logic             w_ok;
    logic             w_ld_ok;
    logic             w_ram_we;
    logic             w_count_ld;
    logic             w_count_st;
    logic             w_err_set;

    // Upper address bits are ignored, so the RAM aliases modulo 4*DEPTH_WORDS.
    assign w_idx   = addr[IDX_W+1:2];
    assign w_rword = r_mem[w_idx];

    dm_lane_fmt u_lane_fmt (
        .i_addr_lo (addr[1:0]),
        .i_dm_type (dm_type),
        .i_wdata   (wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wdata   (w_wdata_al),
        .o_rdata   (w_rdata_ext),
        .o_aligned (w_aligned),
        .o_valid   (w_valid)
    );

    // Access classification. Undefined codes are no-ops and never misaligned;
    // the MMIO window accepts word accesses only.
    assign w_access   = mem_r | mem_w;
    assign w_misalign = w_access && w_valid &&
                        (!w_aligned || (w_is_mmio && (dm_type != DM_WORD)));
    assign w_ok       = w_access && w_valid && !w_misalign;
    // mem_w dominates: a cycle with both strobes is a store, not a load.
    assign w_ld_ok    = mem_r && !mem_w && w_ok;
    assign w_ram_we   = reset && mem_w && w_ok && !w_is_mmio;
    assign w_count_ld = w_ld_ok && !w_is_mmio;
    assign w_count_st = mem_w && w_ok && !w_is_mmio;
    // A new misaligned access is captured when nothing is held, or when the
    // held record is being cleared in the same cycle (the new event wins).
    assign w_err_set  = w_misalign && (!r_err_sticky || err_clr);

    assign misalign   = w_misalign;
    assign err_sticky = r_err_sticky;
    assign err_addr   = r_err_addr;

    // Byte-lane RAM write; only the enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset branch; its contents are undefined until
        // written, and the reset qualifier lives in w_ram_we so a store is dropped
        // while reset is asserted.
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_al[8*i +: 8];
                end
            end
        end
    end

    // Load/store access counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        // NOTE: registered state is updated with non-blocking assignments so every
        // always_ff samples the pre-edge values of the others.
        if (!reset) begin
            r_load_cnt  <= 32'h0;
            r_store_cnt <= 32'h0;
        end else begin
            if (w_count_ld) begin
                r_load_cnt <= r_load_cnt + 32'd1;
            end
            if (w_count_st) begin
                r_store_cnt <= r_store_cnt + 32'd1;
            end
        end
    end

    // Sticky record of the first misaligned access since the last clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_sticky <= 1'b0;
            r_err_addr   <= 32'h0;
        end else if (w_err_set) begin
            r_err_sticky <= 1'b1;
            r_err_addr   <= addr;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_addr   <= 32'h0;
        end
    end

`ifdef DM_MMIO_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_gpio;
    logic [31:0] w_mmio_rdata;
    logic        w_gpio_we;

    assign w_is_mmio = (addr[31:16] == MMIO_BASE_HI);
    // Only the GPIO register is writable; writes to the read-only registers fall through.
    assign w_gpio_we = mem_w && w_ok && w_is_mmio && (addr[15:0] == MMIO_GPIO_OFS);
    assign gpio_out  = r_gpio;

    // Register read mux for the MMIO window; unmapped offsets read as zero.
    always_comb begin
        w_mmio_rdata = 32'h0;
        case (addr[15:0])
            MMIO_CYCLE_OFS:     w_mmio_rdata = r_cycle_cnt;
            MMIO_LOAD_CNT_OFS:  w_mmio_rdata = r_load_cnt;
            MMIO_STORE_CNT_OFS: w_mmio_rdata = r_store_cnt;
            MMIO_GPIO_OFS:      w_mmio_rdata = r_gpio;
            default:            w_mmio_rdata = 32'h0;
        endcase
    end

    // Free-running cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycle_cnt <= 32'h0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    // GPIO output register, written by aligned word stores to its offset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gpio <= 32'h0;
        end else if (w_gpio_we) begin
            r_gpio <= wdata;
        end
    end
`else
    logic w_unused;

    assign w_is_mmio = 1'b0;
    assign gpio_out  = 32'h0;
    // Counters are internal-only and upper address bits only alias in this build.
    assign w_unused  = ^{addr[31:IDX_W+2], r_load_cnt, r_store_cnt};
`endif

    // Load result: extended RAM data or MMIO register, zero for anything else.
    always_comb begin
        rdata = 32'h0;
        if (w_ld_ok) begin
`ifdef DM_MMIO_EN
            rdata = w_is_mmio ? w_mmio_rdata : w_rdata_ext;
`else
            rdata = w_rdata_ext;
`endif
        end
    end

endmodule
